// File: rtl/mem_bist_pkg.sv
// Shared definitions for the memory BIST engine: geometry of the 32x8
// memory under test, test phase and FSM state encodings, the compare
// pipeline entry format and the Galois LFSR step function.
package mem_bist_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 32;
  localparam int ERR_W  = 7;

  // Three read passes of 32 locations bound the error count.
  localparam logic [ERR_W-1:0] ERR_MAX = 7'd96;

  // Right-shifting Galois form of x^8+x^6+x^5+x^4+1.
  localparam logic [DATA_W-1:0] LFSR_TAPS = 8'hB8;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    ADDR  = 2'd1,
    RAND  = 2'd2,
    NONE  = 2'd3
  } phase_e;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_CLR_WR = 4'd1,
    ST_CLR_RD = 4'd2,
    ST_ADR_WR = 4'd3,
    ST_ADR_RD = 4'd4,
    ST_RND_WR = 4'd5,
    ST_RND_RD = 4'd6,
    ST_DRAIN  = 4'd7,
    ST_DONE   = 4'd8
  } state_e;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] exp_data;
    phase_e            phase;
  } cmp_t;

  function automatic logic [DATA_W-1:0] lfsr_step(input logic [DATA_W-1:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : '0);
  endfunction

endpackage

// File: rtl/mem_bist_if.sv
// Memory-side bus between the BIST engine (master) and the 32x8
// synchronous memory (slave).
//   mem_read / mem_write : access strobes, never both high
//   mem_addr             : word address
//   mem_wdata            : write data
//   mem_rdata            : read data, READ_LATENCY cycles after the read
interface mem_bist_if;
  import mem_bist_pkg::*;

  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_read, mem_write, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport slave (
    input  mem_read, mem_write, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/mem_bist_lfsr.sv
// 8-bit Galois LFSR supplying the pseudo-random data pattern.
//   clk, reset : clock and synchronous active-high reset (loads SEED)
//   load       : reload SEED
//   advance    : step the sequence by one
//   value      : current LFSR state
module mem_bist_lfsr
  import mem_bist_pkg::*;
#(
  parameter logic [DATA_W-1:0] SEED = 8'hA5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              advance,
  output logic [DATA_W-1:0] value
);

  always_ff @(posedge clk) begin
    if (reset || load) begin
      value <= SEED;
    end else if (advance) begin
      value <= lfsr_step(value);
    end
  end

endmodule

// File: rtl/mem_bist.sv
// Memory BIST engine: clear-to-zero, data-equals-address and
// pseudo-random passes over a 32x8 synchronous memory, then reports
// pass/fail, error count and the first failing location.
//   clk, reset        : clock, synchronous active-high reset
//   start             : accepted only in IDLE or DONE
//   busy / done / pass: run status; pass valid while done
//   err_count         : total miscompares (saturates, never wraps)
//   first_fail_addr   : address of the first miscompare
//   first_fail_phase  : phase of the first miscompare, NONE if none
//   mem               : memory bus (master side)
//
// state  | meaning
// IDLE   | waiting for start
// CLR_WR | write 0 to every address
// CLR_RD | read back every address, expect 0
// ADR_WR | write {3'b0,addr} to every address
// ADR_RD | read back every address, expect {3'b0,addr}
// RND_WR | write LFSR value to addr i, then go to RND_RD
// RND_RD | read addr i, expect the value just written
// DRAIN  | let the last reads reach the compare stage
// DONE   | results held until start or reset
module mem_bist
  import mem_bist_pkg::*;
#(
  parameter int                READ_LATENCY = 1,  // 1..3
  parameter logic [DATA_W-1:0] LFSR_SEED    = 8'hA5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_count,
  output logic [ADDR_W-1:0] first_fail_addr,
  output logic [1:0]        first_fail_phase,
  mem_bist_if.master        mem
);

  localparam logic [3:0] S_IDLE   = ST_IDLE;
  localparam logic [3:0] S_CLR_WR = ST_CLR_WR;
  localparam logic [3:0] S_CLR_RD = ST_CLR_RD;
  localparam logic [3:0] S_ADR_WR = ST_ADR_WR;
  localparam logic [3:0] S_ADR_RD = ST_ADR_RD;
  localparam logic [3:0] S_RND_WR = ST_RND_WR;
  localparam logic [3:0] S_RND_RD = ST_RND_RD;
  localparam logic [3:0] S_DRAIN  = ST_DRAIN;
  localparam logic [3:0] S_DONE   = ST_DONE;

  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);
  localparam logic [1:0]        DRAIN_LOAD = 2'(READ_LATENCY);

  logic [3:0]        state;
  logic [ADDR_W-1:0] cnt;
  logic [1:0]        drain_cnt;
  logic              read_q;
  logic              write_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] exp_q;
  phase_e            phase_q;
  phase_e            ff_phase;
  logic [DATA_W-1:0] lfsr_val;
  logic              start_ok;
  logic              miscmp;
  logic [ERR_W-1:0]  err_next;
  cmp_t              pipe [READ_LATENCY];
  cmp_t              cmp_out;

  assign mem.mem_read      = read_q;
  assign mem.mem_write     = write_q;
  assign mem.mem_addr      = addr_q;
  assign mem.mem_wdata     = wdata_q;
  assign first_fail_phase  = ff_phase;

  assign start_ok = start && ((state == S_IDLE) || (state == S_DONE));

  mem_bist_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .load    (start_ok),
    .advance (state == S_RND_WR),
    .value   (lfsr_val)
  );

  // Entries enter the pipe one edge after the read is issued (when the
  // memory samples the strobe) and reach the end together with mem_rdata.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < READ_LATENCY; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= '{valid: read_q, addr: addr_q, exp_data: exp_q, phase: phase_q};
      for (int i = 1; i < READ_LATENCY; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign cmp_out  = pipe[READ_LATENCY-1];
  // Case inequality so X/Z read data is flagged as a miscompare.
  assign miscmp   = cmp_out.valid && (mem.mem_rdata !== cmp_out.exp_data);
  assign err_next = (miscmp && (err_count != ERR_MAX)) ? err_count + 7'd1 : err_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= S_IDLE;
      cnt             <= '0;
      drain_cnt       <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      err_count       <= '0;
      first_fail_addr <= '0;
      ff_phase        <= NONE;
      read_q          <= 1'b0;
      write_q         <= 1'b0;
      addr_q          <= '0;
      wdata_q         <= '0;
      exp_q           <= '0;
      phase_q         <= NONE;
    end else begin
      read_q  <= 1'b0;
      write_q <= 1'b0;

      if (miscmp) begin
        err_count <= err_next;
        if (ff_phase == NONE) begin
          first_fail_addr <= cmp_out.addr;
          ff_phase        <= cmp_out.phase;
        end
      end

      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state           <= S_CLR_WR;
            cnt             <= '0;
            done            <= 1'b0;
            pass            <= 1'b0;
            err_count       <= '0;
            first_fail_addr <= '0;
            ff_phase        <= NONE;
          end
        end
        S_CLR_WR: begin
          busy    <= 1'b1;
          write_q <= 1'b1;
          addr_q  <= cnt;
          wdata_q <= '0;
          cnt     <= cnt + 5'd1;
          if (cnt == LAST_ADDR) state <= S_CLR_RD;
        end
        S_CLR_RD: begin
          read_q  <= 1'b1;
          addr_q  <= cnt;
          exp_q   <= '0;
          phase_q <= CLEAR;
          cnt     <= cnt + 5'd1;
          if (cnt == LAST_ADDR) state <= S_ADR_WR;
        end
        S_ADR_WR: begin
          write_q <= 1'b1;
          addr_q  <= cnt;
          wdata_q <= {3'b000, cnt};
          cnt     <= cnt + 5'd1;
          if (cnt == LAST_ADDR) state <= S_ADR_RD;
        end
        S_ADR_RD: begin
          read_q  <= 1'b1;
          addr_q  <= cnt;
          exp_q   <= {3'b000, cnt};
          phase_q <= ADDR;
          cnt     <= cnt + 5'd1;
          if (cnt == LAST_ADDR) state <= S_RND_WR;
        end
        S_RND_WR: begin
          write_q <= 1'b1;
          addr_q  <= cnt;
          wdata_q <= lfsr_val;
          state   <= S_RND_RD;
        end
        S_RND_RD: begin
          // wdata_q still holds the value written on the previous cycle
          read_q  <= 1'b1;
          addr_q  <= cnt;
          exp_q   <= wdata_q;
          phase_q <= RAND;
          cnt     <= cnt + 5'd1;
          if (cnt == LAST_ADDR) begin
            state     <= S_DRAIN;
            drain_cnt <= DRAIN_LOAD;
          end else begin
            state <= S_RND_WR;
          end
        end
        S_DRAIN: begin
          if (drain_cnt == 2'd0) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_next == '0);
          end else begin
            drain_cnt <= drain_cnt - 2'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bist.sv
`timescale 1ns/1ps
module tb_mem_bist;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic start3 = 1'b0;
  int   fault = 0;   // 0 none, 1 data bit0 stuck-at-1, 2 addr bit4 ignored

  always #5 clk = ~clk;

  logic       busy, done, pass;
  logic [6:0] err_count;
  logic [4:0] ffa;
  logic [1:0] ffp;
  logic       busy3, done3, pass3;
  logic [6:0] err3;
  logic [4:0] ffa3;
  logic [1:0] ffp3;

  mem_bist_if bus1();
  mem_bist_if bus3();

  mem_bist #(.READ_LATENCY(1), .LFSR_SEED(8'hA5)) u_dut (
    .clk(clk), .reset(reset), .start(start),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_fail_addr(ffa), .first_fail_phase(ffp),
    .mem(bus1.master)
  );

  mem_bist #(.READ_LATENCY(3), .LFSR_SEED(8'hA5)) u_dut3 (
    .clk(clk), .reset(reset), .start(start3),
    .busy(busy3), .done(done3), .pass(pass3), .err_count(err3),
    .first_fail_addr(ffa3), .first_fail_phase(ffp3),
    .mem(bus3.master)
  );

  // memory for latency-1 DUT, with optional faults
  logic [7:0] mem1 [32];
  logic [7:0] rdata1;
  logic [4:0] a1;
  assign a1 = (fault == 2) ? {1'b0, bus1.mem_addr[3:0]} : bus1.mem_addr;
  always @(posedge clk) begin
    if (bus1.mem_write) mem1[a1] <= bus1.mem_wdata;
    if (bus1.mem_read) rdata1 <= (fault == 1) ? (mem1[a1] | 8'h01) : mem1[a1];
  end
  assign bus1.mem_rdata = rdata1;

  // fault-free memory for latency-3 DUT
  logic [7:0] mem3 [32];
  logic [7:0] r3a, r3b, r3c;
  always @(posedge clk) begin
    if (bus3.mem_write) mem3[bus3.mem_addr] <= bus3.mem_wdata;
    if (bus3.mem_read) r3a <= mem3[bus3.mem_addr];
    r3b <= r3a;
    r3c <= r3b;
  end
  assign bus3.mem_rdata = r3c;

  logic [7:0] wr_log[$];
  always @(posedge clk) if (bus1.mem_write) wr_log.push_back(bus1.mem_wdata);

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // returns the absolute edge at which done was seen, -1 on timeout
  task automatic wait_done(input int from_edge, input int limit, output int at);
    at = -1;
    for (int k = from_edge + 1; k <= from_edge + limit; k++) begin
      step();
      if (done) begin
        at = k;
        break;
      end
    end
  endtask

  task automatic check_reset(input string t);
    check({t, "_busy"},  busy, 0);
    check({t, "_done"},  done, 0);
    check({t, "_pass"},  pass, 0);
    check({t, "_err"},   err_count, 0);
    check({t, "_ffa"},   ffa, 0);
    check({t, "_ffp"},   ffp, 3);
    check({t, "_rd"},    bus1.mem_read, 0);
    check({t, "_wr"},    bus1.mem_write, 0);
    check({t, "_addr"},  bus1.mem_addr, 0);
    check({t, "_wdata"}, bus1.mem_wdata, 0);
  endtask

  function automatic logic [7:0] ref_next(input logic [7:0] s);
    return {1'b0, s[7:1]} ^ (s[0] ? 8'hB8 : 8'h00);
  endfunction

  // {read, write, addr} expected for issue slot i (0..191)
  function automatic logic [6:0] exp_issue(input int i);
    int j;
    if (i < 32)  return {2'b01, 5'(i)};
    if (i < 64)  return {2'b10, 5'(i - 32)};
    if (i < 96)  return {2'b01, 5'(i - 64)};
    if (i < 128) return {2'b10, 5'(i - 96)};
    j = i - 128;
    return {((j % 2) == 1), ((j % 2) == 0), 5'(j / 2)};
  endfunction

  initial begin
    int at;
    int zeros;
    int stuck_errs;
    logic [7:0] s;
    logic [7:0] rnd_ref[$];

    // reference random sequence and its count of even values
    zeros = 0;
    s = 8'hA5;
    for (int i = 0; i < 32; i++) begin
      rnd_ref.push_back(s);
      if (s[0] == 1'b0) zeros++;
      s = ref_next(s);
    end
    stuck_errs = 32 + 16 + zeros;

    reset = 1'b1;
    step();
    step();
    check_reset("por");
    check("por_busy3", busy3, 0);
    check("por_ffp3", ffp3, 3);
    reset = 1'b0;
    step();

    // fault-free, latency 1
    fault = 0;
    wr_log.delete();
    start = 1'b1;
    step();                       // edge 0
    start = 1'b0;
    check("t1_busy_e0", busy, 0);
    step();                       // edge 1
    check("t1_busy_e1", busy, 1);
    check("t1_first_wr", {bus1.mem_read, bus1.mem_write, bus1.mem_addr, bus1.mem_wdata},
          {1'b0, 1'b1, 5'd0, 8'd0});
    wait_done(1, 400, at);
    check("t1_done_edge", at, 194);
    check("t1_pass", pass, 1);
    check("t1_busy_end", busy, 0);
    check("t1_err", err_count, 0);
    check("t1_ffp", ffp, 3);
    check("t1_strobes", {bus1.mem_read, bus1.mem_write}, 0);
    check("t1_log_size", wr_log.size(), 96);
    if (wr_log.size() >= 96)
      for (int i = 0; i < 32; i++)
        check($sformatf("t1_rnd_%0d", i), wr_log[64 + i], rnd_ref[i]);

    // data bit 0 stuck at 1
    fault = 1;
    start = 1'b1;
    step();
    start = 1'b0;
    check("t2_done_clr", done, 0);
    wait_done(0, 400, at);
    check("t2_done_edge", at, 194);
    check("t2_err", err_count, stuck_errs);
    check("t2_ffa", ffa, 0);
    check("t2_ffp", ffp, 0);
    check("t2_pass", pass, 0);

    // address bit 4 ignored
    fault = 2;
    start = 1'b1;
    step();
    start = 1'b0;
    check("t3_ffp_clr", ffp, 3);
    wait_done(0, 400, at);
    check("t3_done_edge", at, 194);
    check("t3_err", err_count, 16);
    check("t3_ffa", ffa, 0);
    check("t3_ffp", ffp, 1);
    check("t3_pass", pass, 0);

    // reset mid-test, then restart
    fault = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= 50; k++) step();
    check("t4_busy_e50", busy, 1);
    reset = 1'b1;
    step();                       // edge 51
    check_reset("t4_rst");
    reset = 1'b0;
    step();
    wr_log.delete();
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done(0, 400, at);
    check("t4_done_edge", at, 194);
    check("t4_pass", pass, 1);
    check("t4_log_size", wr_log.size(), 96);
    if (wr_log.size() >= 96)
      for (int i = 0; i < 32; i++)
        check($sformatf("t4_rnd_%0d", i), wr_log[64 + i], rnd_ref[i]);

    // start while busy ignored; start in DONE clears and reruns
    fault = 1;
    start = 1'b1;
    step();                       // edge 0
    start = 1'b0;
    at = -1;
    for (int k = 1; k <= 400; k++) begin
      if (k == 10 || k == 100) start = 1'b1;
      step();
      start = 1'b0;
      if (done) begin
        at = k;
        break;
      end
    end
    check("t5_done_edge", at, 194);
    check("t5_err", err_count, stuck_errs);
    for (int k = ((at < 0) ? 0 : at) + 1; k < 200; k++) step();
    start = 1'b1;
    step();                       // edge 200
    start = 1'b0;
    check("t5_err_clr", err_count, 0);
    check("t5_done_clr", done, 0);
    check("t5_ffp_clr", ffp, 3);
    check("t5_pass_clr", pass, 0);
    wait_done(200, 400, at);
    check("t5_done2_edge", at, 394);
    check("t5_err2", err_count, stuck_errs);

    // latency 3, fault-free, per-cycle strobe/address checks
    start3 = 1'b1;
    step();                       // edge 0
    start3 = 1'b0;
    at = -1;
    for (int k = 1; k <= 400; k++) begin
      step();
      check($sformatf("t6_excl_%0d", k), bus3.mem_read & bus3.mem_write, 0);
      if (k <= 192)
        check($sformatf("t6_issue_%0d", k), {bus3.mem_read, bus3.mem_write, bus3.mem_addr},
              exp_issue(k - 1));
      else
        check($sformatf("t6_quiet_%0d", k), {bus3.mem_read, bus3.mem_write}, 0);
      if (done3) begin
        at = k;
        break;
      end
    end
    check("t6_done_edge", at, 196);
    check("t6_pass", pass3, 1);
    check("t6_err", err3, 0);
    check("t6_ffp", ffp3, 3);
    check("t6_busy", busy3, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
